// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared two-digit seven-segment display.
// Four requesters compete; the winner is shown hex-decoded with digit multiplexing.
module seg_display_arbiter #(
  parameter int REFRESH_DIV = 1024,
  parameter int DWELL       = 25_000_000
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [7:0]  digit_seg,
  output logic [1:0]  digit_cath,
  output logic        dbg_state
);

  // Handshake: req is a level held by each requester for as long as it wants the
  // display; grant is a registered one-hot answer and the requester owns the display
  // while its grant bit is high. Dropping req releases the display on the next edge.

  localparam int SCAN_W  = $clog2(REFRESH_DIV);
  localparam int DWELL_W = $clog2(DWELL);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(REFRESH_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [3:0]         r_grant;
  logic [1:0]         r_owner;
  logic               r_busy;
  logic [DWELL_W-1:0] r_dwell;
  logic [7:0]         r_disp_data;
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic               r_scan_sel;
  logic [7:0]         r_seg;
  logic [1:0]         r_cath;

  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_found;
  logic [3:0] w_owner_oh;
  logic [3:0] w_others;
  logic [7:0] w_owner_data;
  logic [7:0] w_winner_data;
  logic [3:0] w_disp_nib;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hFC;
      4'h1: seg = 8'h60;
      4'h2: seg = 8'hDA;
      4'h3: seg = 8'hF2;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'hB6;
      4'h6: seg = 8'hBE;
      4'h7: seg = 8'hE0;
      4'h8: seg = 8'hFE;
      4'h9: seg = 8'hF6;
      4'hA: seg = 8'hEE;
      4'hB: seg = 8'h3E;
      4'hC: seg = 8'h9C;
      4'hD: seg = 8'h7A;
      4'hE: seg = 8'h9E;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Search starts just after the last owner, so the previous owner is checked last.
  always_comb begin
    w_winner = r_owner;
    w_found  = 1'b0;
    w_idx    = r_owner;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_owner + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_owner_oh    = 4'b0001 << r_owner;
  assign w_others      = req & ~w_owner_oh;
  assign w_owner_data  = data[{r_owner, 3'b000} +: 8];
  assign w_winner_data = data[{w_winner, 3'b000} +: 8];
  assign w_disp_nib    = r_scan_sel ? r_disp_data[7:4] : r_disp_data[3:0];

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= 4'b0000;
      r_owner     <= 2'd3;
      r_busy      <= 1'b0;
      r_dwell     <= '0;
      r_disp_data <= 8'h00;
      r_scan_cnt  <= '0;
      r_scan_sel  <= 1'b0;
      r_seg       <= 8'h00;
      r_cath      <= 2'b00;
    end else begin
      if (r_scan_cnt == SCAN_MAX) begin
        r_scan_cnt <= '0;
        r_scan_sel <= ~r_scan_sel;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end

      // Display lags the arbitration by one edge, so the gap cycle is blank.
      if (r_state == ST_GRANT) begin
        r_cath <= r_scan_sel ? 2'b10 : 2'b01;
        r_seg  <= hex_to_seg(w_disp_nib);
      end else begin
        r_cath <= 2'b00;
        r_seg  <= 8'h00;
      end

      case (r_state)
        ST_IDLE: begin
          if (req != 4'b0000) begin
            r_owner     <= w_winner;
            r_grant     <= 4'b0001 << w_winner;
            r_busy      <= 1'b1;
            r_dwell     <= '0;
            r_disp_data <= w_winner_data;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_disp_data <= w_owner_data;
          if (r_dwell != DWELL_MAX) begin
            r_dwell <= r_dwell + 1'b1;
          end
          if (!req[r_owner] || (r_dwell == DWELL_MAX && w_others != 4'b0000)) begin
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign owner      = r_owner;
  assign busy       = r_busy;
  assign digit_seg  = r_seg;
  assign digit_cath = r_cath;
  assign dbg_state  = (r_state == ST_GRANT);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed-vector bench for seg_display_arbiter with REFRESH_DIV=4, DWELL=8.
// Scan phase is tracked by counting clock edges since reset release.
module tb_seg_display_arbiter;

  localparam int REFRESH_DIV = 4;
  localparam int DWELL       = 8;

  logic        clk_50m = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  req     = 4'b0000;
  logic [31:0] data    = 32'h0;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  digit_seg;
  logic [1:0]  digit_cath;
  logic        dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc;

  seg_display_arbiter #(
    .REFRESH_DIV(REFRESH_DIV),
    .DWELL      (DWELL)
  ) dut (
    .clk_50m   (clk_50m),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy),
    .digit_seg (digit_seg),
    .digit_cath(digit_cath),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Display sampled after edge n reflects scan_sel after n-1 edges.
  function automatic logic exp_sel(input int n);
    return ((n - 1) / REFRESH_DIV) % 2 == 1;
  endfunction

  task automatic do_reset();
    @(negedge clk_50m);
    reset = 1'b1;
    req   = 4'b0000;
    data  = 32'h0;
    @(negedge clk_50m);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_50m);
    reset = 1'b1;
    req   = 4'b0000;
    @(negedge clk_50m);
    checks++;
    if ({grant, busy, digit_seg, digit_cath, dbg_state} !== 16'h0 || owner !== 2'd3) begin
      errors++;
      $display("FAIL reset_values: grant=%b busy=%b seg=%h cath=%b owner=%0d state=%b required 0000/0/00/00/3/0",
               grant, busy, digit_seg, digit_cath, owner, dbg_state);
    end
    reset = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_50m);
      checks++;
      if ({grant, busy, digit_seg, digit_cath} !== 15'h0) begin
        errors++;
        $display("FAIL idle_quiet cyc %0d: grant=%b busy=%b seg=%h cath=%b required all zero",
                 cyc, grant, busy, digit_seg, digit_cath);
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] ec;
    logic [7:0] es;
    do_reset();
    data[7:0] = 8'h3A;
    req       = 4'b0001;
    @(negedge clk_50m);
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || owner !== 2'd0 || digit_cath !== 2'b00) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b owner=%0d cath=%b required 0001/1/0/00",
               grant, busy, owner, digit_cath);
    end
    for (int n = 0; n < 16; n++) begin
      @(negedge clk_50m);
      ec = exp_sel(cyc) ? 2'b10 : 2'b01;
      es = exp_sel(cyc) ? 8'hF2 : 8'hEE;
      checks++;
      if (digit_cath !== ec || digit_seg !== es) begin
        errors++;
        $display("FAIL single_scan cyc %0d: cath=%b seg=%h required %b/%h", cyc, digit_cath, digit_seg, ec, es);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    int pos;
    do_reset();
    data = 32'h0055_6600;
    req  = 4'b0110;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk_50m);
      pos = (n - 1) % (DWELL + 1);
      if (pos == DWELL) eg = 4'b0000;
      else              eg = (((n - 1) / (DWELL + 1)) % 2 == 1) ? 4'b0100 : 4'b0010;
      checks++;
      if (grant !== eg || busy !== (eg != 4'b0000)) begin
        errors++;
        $display("FAIL rr_grant edge %0d: grant=%b busy=%b required %b", n, grant, busy, eg);
      end
      if (pos == 0) begin
        checks++;
        if (digit_cath !== 2'b00 || digit_seg !== 8'h00) begin
          errors++;
          $display("FAIL rr_blank edge %0d: cath=%b seg=%h required 00/00", n, digit_cath, digit_seg);
        end
      end
    end
  endtask

  task automatic test_release();
    logic [1:0] ec;
    logic [7:0] es;
    do_reset();
    data = 32'h0044_0081;
    req  = 4'b0100;
    @(negedge clk_50m);
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL rel_first: grant=%b owner=%0d required 0100/2", grant, owner);
    end
    repeat (2) @(negedge clk_50m);
    req = 4'b0001;
    @(negedge clk_50m);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rel_drop: grant=%b busy=%b required 0000/0", grant, busy);
    end
    @(negedge clk_50m);
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0 || digit_cath !== 2'b00 || digit_seg !== 8'h00) begin
      errors++;
      $display("FAIL rel_regrant: grant=%b owner=%0d cath=%b seg=%h required 0001/0/00/00",
               grant, owner, digit_cath, digit_seg);
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk_50m);
      ec = exp_sel(cyc) ? 2'b10 : 2'b01;
      es = exp_sel(cyc) ? 8'hFE : 8'h60;
      checks++;
      if (digit_cath !== ec || digit_seg !== es) begin
        errors++;
        $display("FAIL rel_display cyc %0d: cath=%b seg=%h required %b/%h", cyc, digit_cath, digit_seg, ec, es);
      end
    end
  endtask

  task automatic test_sole_data();
    logic [7:0] es;
    do_reset();
    req = 4'b1000;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_50m);
      checks++;
      if (grant !== 4'b1000 || owner !== 2'd3) begin
        errors++;
        $display("FAIL sole_hold cyc %0d: grant=%b owner=%0d required 1000/3", cyc, grant, owner);
      end
    end
    data[31:24] = 8'h5C;
    @(negedge clk_50m);
    checks++;
    if (digit_seg !== 8'hFC) begin
      errors++;
      $display("FAIL data_old cyc %0d: seg=%h required fc", cyc, digit_seg);
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk_50m);
      es = exp_sel(cyc) ? 8'hB6 : 8'h9C;
      checks++;
      if (digit_seg !== es) begin
        errors++;
        $display("FAIL data_new cyc %0d: seg=%h required %h", cyc, digit_seg, es);
      end
    end
    // Dwell is long saturated, so a new requester preempts at once.
    req = 4'b1001;
    @(negedge clk_50m);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL sat_preempt: grant=%b required 0000", grant);
    end
    @(negedge clk_50m);
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL sat_next: grant=%b owner=%0d required 0001/0", grant, owner);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    repeat (3) @(negedge clk_50m);
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL mid_pre: grant=%b required 0100", grant);
    end
    #5;
    reset = 1'b1;
    #1;
    checks++;
    if ({grant, busy, digit_seg, digit_cath} !== 15'h0 || owner !== 2'd3) begin
      errors++;
      $display("FAIL mid_async: grant=%b busy=%b seg=%h cath=%b owner=%0d required zeros/3",
               grant, busy, digit_seg, digit_cath, owner);
    end
    @(negedge clk_50m);
    checks++;
    if ({grant, busy, digit_seg, digit_cath} !== 15'h0 || owner !== 2'd3) begin
      errors++;
      $display("FAIL mid_held: grant=%b busy=%b seg=%h cath=%b owner=%0d required zeros/3",
               grant, busy, digit_seg, digit_cath, owner);
    end
    req   = 4'b1010;
    reset = 1'b0;
    @(negedge clk_50m);
    checks++;
    if (grant !== 4'b0010 || owner !== 2'd1) begin
      errors++;
      $display("FAIL mid_first: grant=%b owner=%0d required 0010/1", grant, owner);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_release();
    test_sole_data();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
